// File: rtl/mul_issue_sched_pkg.sv
// Shared widths and payload types for the multiply issue scheduler and its result FIFO.
package mul_issue_sched_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned PRF_LEN     = 6;
   localparam int unsigned ROB_LEN     = 5;
   localparam int unsigned STAGE       = 8;
   localparam int unsigned DEF_MUL_LAT = STAGE;

   typedef enum logic [1:0] {
      MUL_MUL    = 2'd0,
      MUL_MULH   = 2'd1,
      MUL_MULHSU = 2'd2,
      MUL_MULHU  = 2'd3
   } MUL_FUNC;

   typedef struct packed {
      logic [XLEN-1:0]    opa;
      logic [XLEN-1:0]    opb;
      MUL_FUNC            mul_func;
      logic [PRF_LEN-1:0] dest_preg_idx;
      logic [ROB_LEN-1:0] rob_idx;
      logic [XLEN-1:0]    PC;
   } RS_MUL_PACKET;

   typedef struct packed {
      logic [XLEN-1:0]    value;
      logic [PRF_LEN-1:0] prf_idx;
      logic [ROB_LEN-1:0] rob_idx;
      logic [XLEN-1:0]    PC;
   } MUL_CDB_PACKET;

   typedef struct packed {
      logic               valid;
      logic [PRF_LEN-1:0] prf_idx;
      logic [ROB_LEN-1:0] rob_idx;
      logic [XLEN-1:0]    PC;
   } MUL_TAG;

endpackage

// File: rtl/mul_issue_sched_result_fifo.sv
// Small result FIFO between the multiplier and the CDB; push and pop may coincide even when full.
module mul_result_fifo
   import mul_issue_sched_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear_i,
   input  logic          push_i,
   input  MUL_CDB_PACKET data_i,
   input  logic          pop_i,
   output MUL_CDB_PACKET data_o,
   output logic          valid_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   MUL_CDB_PACKET    mem_q [DEPTH];
   MUL_CDB_PACKET    mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Next-state: a pop frees the slot a same-cycle push needs when full.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      full     = (count_q == CNT_W'(DEPTH));
      do_pop   = pop_i && (count_q != '0);
      do_push  = push_i && (!full || do_pop);

      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign valid_o = (count_q != '0);

endmodule

// File: rtl/mul_issue_sched.sv
// Round-robin issue scheduler for the pipelined multiplier: carries op metadata in a tag pipe
// alongside the datapath and buffers results under a credit limit so CDB stalls never drop one.
module mul_issue_sched
   import mul_issue_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned MUL_LAT    = DEF_MUL_LAT,
   parameter int unsigned OBUF_DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  RS_MUL_PACKET [NUM_REQ-1:0] req_packet,
   output logic [NUM_REQ-1:0]         req_grant,
   input  logic                       flush,
   output logic                       mul_start,
   output RS_MUL_PACKET               mul_packet,
   input  logic                       mul_done,
   input  logic [XLEN-1:0]            mul_value,
   output logic                       cdb_valid,
   output logic [XLEN-1:0]            cdb_value,
   output logic [PRF_LEN-1:0]         cdb_prf_idx,
   output logic [ROB_LEN-1:0]         cdb_rob_idx,
   output logic [XLEN-1:0]            cdb_PC,
   input  logic                       cdb_ack,
   output logic                       busy,
   output logic                       protocol_err
);

   localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CRED_W = $clog2(OBUF_DEPTH + 1);

   logic [IDX_W-1:0]  rr_q, rr_d;
   logic [CRED_W-1:0] credit_q, credit_d;
   logic              mul_start_q, mul_start_d;
   RS_MUL_PACKET      mul_packet_q, mul_packet_d;
   logic              err_q, err_d;

   // Stage 0 is co-timed with mul_start; stage MUL_LAT lines up with the matching mul_done.
   MUL_TAG            tag_q [MUL_LAT+1];
   MUL_TAG            tag_d [MUL_LAT+1];

   logic              grant_any;
   logic [IDX_W-1:0]  grant_idx;
   logic [IDX_W-1:0]  cand_idx;
   int unsigned       cand;
   logic              head_valid;
   logic              op_lost;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_valid;
   MUL_CDB_PACKET     push_data;
   MUL_CDB_PACKET     fifo_head;

   // Round-robin pick: first valid requester at or after rr_q, only while credit remains.
   always_comb begin
      req_grant = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = 0;
      cand_idx  = '0;
      if (reset && !flush && (credit_q != '0)) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand     = (32'(rr_q) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!grant_any && req_valid[cand_idx]) begin
               grant_any = 1'b1;
               grant_idx = cand_idx;
            end
         end
      end
      if (grant_any) begin
         req_grant[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      rr_d         = rr_q;
      mul_start_d  = grant_any;
      mul_packet_d = mul_packet_q;
      head_valid   = tag_q[MUL_LAT].valid;
      fifo_push    = mul_done && head_valid;
      op_lost      = head_valid && !mul_done;
      fifo_pop     = fifo_valid && cdb_ack;
      err_d        = err_q | op_lost;

      push_data.value   = mul_value;
      push_data.prf_idx = tag_q[MUL_LAT].prf_idx;
      push_data.rob_idx = tag_q[MUL_LAT].rob_idx;
      push_data.PC      = tag_q[MUL_LAT].PC;

      tag_d[0].valid   = grant_any;
      tag_d[0].prf_idx = req_packet[grant_idx].dest_preg_idx;
      tag_d[0].rob_idx = req_packet[grant_idx].rob_idx;
      tag_d[0].PC      = req_packet[grant_idx].PC;
      for (int unsigned k = 1; k <= MUL_LAT; k++) begin
         tag_d[k] = tag_q[k-1];
      end

      if (grant_any) begin
         mul_packet_d = req_packet[grant_idx];
         rr_d         = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end

      credit_d = credit_q + CRED_W'(fifo_pop) + CRED_W'(op_lost) - CRED_W'(grant_any);

      // Flush squashes every tag (including the op issuing this cycle) and the FIFO.
      if (flush) begin
         for (int unsigned k = 0; k <= MUL_LAT; k++) begin
            tag_d[k].valid = 1'b0;
         end
         credit_d = CRED_W'(OBUF_DEPTH);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_q         <= '0;
         credit_q     <= CRED_W'(OBUF_DEPTH);
         mul_start_q  <= 1'b0;
         mul_packet_q <= '0;
         err_q        <= 1'b0;
         for (int unsigned k = 0; k <= MUL_LAT; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         rr_q         <= rr_d;
         credit_q     <= credit_d;
         mul_start_q  <= mul_start_d;
         mul_packet_q <= mul_packet_d;
         err_q        <= err_d;
         for (int unsigned k = 0; k <= MUL_LAT; k++) begin
            tag_q[k] <= tag_d[k];
         end
      end
   end

   mul_result_fifo #(
      .DEPTH (OBUF_DEPTH)
   ) u_obuf (
      .clock   (clock),
      .reset   (reset),
      .clear_i (flush),
      .push_i  (fifo_push),
      .data_i  (push_data),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .valid_o (fifo_valid)
   );

   always_comb begin
      busy = fifo_valid;
      for (int unsigned k = 0; k <= MUL_LAT; k++) begin
         busy = busy | tag_q[k].valid;
      end
   end

   assign mul_start    = mul_start_q;
   assign mul_packet   = mul_packet_q;
   assign cdb_valid    = fifo_valid;
   assign cdb_value    = fifo_head.value;
   assign cdb_prf_idx  = fifo_head.prf_idx;
   assign cdb_rob_idx  = fifo_head.rob_idx;
   assign cdb_PC       = fifo_head.PC;
   assign protocol_err = err_q;

endmodule

// File: tb/tb_mul_issue_sched.sv
// Bench for mul_issue_sched: directed scenarios plus random traffic against an op-queue model.
module tb_mul_issue_sched;
   import mul_issue_sched_pkg::*;

   localparam int unsigned NUM_REQ    = 2;
   localparam int unsigned MUL_LAT    = DEF_MUL_LAT;
   localparam int unsigned OBUF_DEPTH = 4;
   localparam int unsigned IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic                       clock = 1'b0;
   logic                       reset = 1'b0;
   logic [NUM_REQ-1:0]         req_valid;
   RS_MUL_PACKET [NUM_REQ-1:0] req_packet;
   logic [NUM_REQ-1:0]         req_grant;
   logic                       flush;
   logic                       mul_start;
   RS_MUL_PACKET               mul_packet;
   logic                       mul_done;
   logic [XLEN-1:0]            mul_value;
   logic                       cdb_valid;
   logic [XLEN-1:0]            cdb_value;
   logic [PRF_LEN-1:0]         cdb_prf_idx;
   logic [ROB_LEN-1:0]         cdb_rob_idx;
   logic [XLEN-1:0]            cdb_PC;
   logic                       cdb_ack;
   logic                       busy;
   logic                       protocol_err;

   always #5 clock = ~clock;

   mul_issue_sched #(
      .NUM_REQ    (NUM_REQ),
      .MUL_LAT    (MUL_LAT),
      .OBUF_DEPTH (OBUF_DEPTH)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_packet   (req_packet),
      .req_grant    (req_grant),
      .flush        (flush),
      .mul_start    (mul_start),
      .mul_packet   (mul_packet),
      .mul_done     (mul_done),
      .mul_value    (mul_value),
      .cdb_valid    (cdb_valid),
      .cdb_value    (cdb_value),
      .cdb_prf_idx  (cdb_prf_idx),
      .cdb_rob_idx  (cdb_rob_idx),
      .cdb_PC       (cdb_PC),
      .cdb_ack      (cdb_ack),
      .busy         (busy),
      .protocol_err (protocol_err)
   );

   // Multiplier stand-in: never reset, so ops in flight across a reset or flush still pulse done.
   logic [MUL_LAT-1:0] m_v = '0;
   logic [XLEN-1:0]    m_val [MUL_LAT];
   always @(posedge clock) begin
      m_v      <= {m_v[MUL_LAT-2:0], mul_start};
      m_val[0] <= XLEN'(mul_packet.opa * mul_packet.opb);
      for (int k = 1; k < MUL_LAT; k++) m_val[k] <= m_val[k-1];
   end
   assign mul_done  = m_v[MUL_LAT-1];
   assign mul_value = m_val[MUL_LAT-1];

   // Model: ops granted and not yet acked or flushed, oldest first.
   typedef struct {
      int unsigned  gcyc;
      RS_MUL_PACKET pkt;
   } op_t;

   op_t          q[$];
   int unsigned  cyc = 0;
   int unsigned  rr_m = 0;
   bit           prev_g = 1'b0;
   RS_MUL_PACKET prev_pkt = '0;
   int unsigned  n_chk = 0;
   int unsigned  n_pass = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
   endtask

   task automatic rand_pkts();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_packet[i].opa           = $urandom();
         req_packet[i].opb           = $urandom();
         req_packet[i].mul_func      = MUL_MUL;
         req_packet[i].dest_preg_idx = PRF_LEN'($urandom());
         req_packet[i].rob_idx       = ROB_LEN'($urandom());
         req_packet[i].PC            = $urandom();
      end
   endtask

   // One cycle: drive at negedge, check mid-cycle, advance the model across the posedge.
   task automatic step(input logic [NUM_REQ-1:0] rv, input logic fl, input logic ack);
      logic [NUM_REQ-1:0] eg;
      logic [XLEN-1:0]    ev_val;
      bit                 g;
      bit                 ev;
      int unsigned        gi;
      int unsigned        c;
      op_t                e;
      req_valid = rv;
      flush     = fl;
      cdb_ack   = ack;
      #1;
      eg = '0;
      g  = 1'b0;
      gi = 0;
      if (!fl && (q.size() < OBUF_DEPTH)) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            c = (rr_m + k) % NUM_REQ;
            if (!g && rv[IW'(c)]) begin
               g  = 1'b1;
               gi = c;
            end
         end
      end
      if (g) eg[IW'(gi)] = 1'b1;
      ev = (q.size() > 0) && (q[0].gcyc + MUL_LAT + 2 <= cyc);

      chk("grant", 128'(req_grant), 128'(eg));
      chk("mul_start", 128'(mul_start), 128'(prev_g));
      if (prev_g) chk("mul_packet", 128'(mul_packet), 128'(prev_pkt));
      chk("cdb_valid", 128'(cdb_valid), 128'(ev));
      if (ev) begin
         ev_val = XLEN'(q[0].pkt.opa * q[0].pkt.opb);
         chk("cdb_value", 128'(cdb_value), 128'(ev_val));
         chk("cdb_prf", 128'(cdb_prf_idx), 128'(q[0].pkt.dest_preg_idx));
         chk("cdb_rob", 128'(cdb_rob_idx), 128'(q[0].pkt.rob_idx));
         chk("cdb_pc", 128'(cdb_PC), 128'(q[0].pkt.PC));
      end
      chk("busy", 128'(busy), 128'((q.size() > 0) && (q[0].gcyc < cyc)));
      chk("protocol_err", 128'(protocol_err), 128'(0));

      @(posedge clock);
      if (fl) begin
         q.delete();
      end else begin
         if (ev && ack) void'(q.pop_front());
         if (g) begin
            e.gcyc = cyc;
            e.pkt  = req_packet[IW'(gi)];
            q.push_back(e);
            rr_m = (gi + 1) % NUM_REQ;
         end
      end
      prev_g = g;
      if (g) prev_pkt = req_packet[IW'(gi)];
      cyc++;
      @(negedge clock);
   endtask

   task automatic do_reset(input int unsigned hold);
      reset = 1'b0;
      #1;
      chk("rst_grant", 128'(req_grant), 128'(0));
      chk("rst_mul_start", 128'(mul_start), 128'(0));
      chk("rst_mul_packet", 128'(mul_packet), 128'(0));
      chk("rst_cdb_valid", 128'(cdb_valid), 128'(0));
      chk("rst_cdb_value", 128'(cdb_value), 128'(0));
      chk("rst_cdb_prf", 128'(cdb_prf_idx), 128'(0));
      chk("rst_cdb_rob", 128'(cdb_rob_idx), 128'(0));
      chk("rst_cdb_pc", 128'(cdb_PC), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_protocol_err", 128'(protocol_err), 128'(0));
      repeat (hold) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      q.delete();
      rr_m   = 0;
      prev_g = 1'b0;
      cyc   += hold;
   endtask

   initial begin
      req_valid = '0;
      flush     = 1'b0;
      cdb_ack   = 1'b0;
      rand_pkts();
      @(negedge clock);
      do_reset(2);

      // Single op: 3 * 5 reaches the CDB ten cycles after its grant.
      req_packet[0] = '{opa: 32'd3, opb: 32'd5, mul_func: MUL_MUL,
                        dest_preg_idx: 6'd7, rob_idx: 5'd3, PC: 32'h1000};
      step(2'b01, 1'b0, 1'b0);
      repeat (9) step(2'b00, 1'b0, 1'b0);
      chk("single_valid", 128'(cdb_valid), 128'(1));
      chk("single_value", 128'(cdb_value), 128'(15));
      chk("single_rob", 128'(cdb_rob_idx), 128'(3));
      repeat (3) step(2'b00, 1'b0, 1'b1);
      chk("single_idle", 128'(busy), 128'(0));

      // Contention, both requesters held for four cycles.
      repeat (4) begin
         rand_pkts();
         step(2'b11, 1'b0, 1'b1);
      end
      repeat (14) step(2'b00, 1'b0, 1'b1);

      // Back-pressure: credits cap grants at four; one ack frees exactly one grant.
      repeat (16) begin
         rand_pkts();
         step(2'b11, 1'b0, 1'b0);
      end
      step(2'b11, 1'b0, 1'b1);
      repeat (4) begin
         rand_pkts();
         step(2'b11, 1'b0, 1'b0);
      end
      repeat (16) step(2'b00, 1'b0, 1'b1);

      // Flush with an op issuing in the flush cycle; late dones must be dropped.
      rand_pkts();
      step(2'b01, 1'b0, 1'b0);
      step(2'b00, 1'b0, 1'b0);
      step(2'b00, 1'b0, 1'b0);
      step(2'b10, 1'b0, 1'b0);
      step(2'b11, 1'b1, 1'b1);
      rand_pkts();
      step(2'b11, 1'b0, 1'b1);
      repeat (16) step(2'b00, 1'b0, 1'b1);

      // Reset mid-operation, then a fresh op completes normally.
      repeat (4) begin
         rand_pkts();
         step(2'b11, 1'b0, 1'b1);
      end
      do_reset(2);
      rand_pkts();
      step(2'b01, 1'b0, 1'b1);
      repeat (14) step(2'b00, 1'b0, 1'b1);

      // Full FIFO: three buffered, ack lands on the cycle the fourth result arrives.
      repeat (4) begin
         rand_pkts();
         step(2'b01, 1'b0, 1'b0);
      end
      repeat (8) step(2'b00, 1'b0, 1'b0);
      step(2'b00, 1'b0, 1'b1);
      step(2'b00, 1'b0, 1'b0);
      repeat (6) step(2'b00, 1'b0, 1'b1);

      // Random traffic with occasional flushes and CDB stalls.
      repeat (300) begin
         rand_pkts();
         step(NUM_REQ'($urandom()), ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 60));
      end
      repeat (20) step(2'b00, 1'b0, 1'b1);
      chk("final_idle", 128'(busy), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
